// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: arbitrates interrupts and ECALL/EBREAK/MRET,
// drains the pipeline, strobes the CSR file once and redirects fetch.
module trap_controller #(
  parameter int unsigned MAX_DRAIN = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mstatus,
  input  logic [31:0] mie,
  input  logic [31:0] mip,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  input  logic [31:0] ex_pc,
  input  logic        ex_valid,
  input  logic        ecall_in,
  input  logic        ebreak_in,
  input  logic        mret_in,
  input  logic        pipe_drained,
  output logic        stall_req,
  output logic        flush_req,
  output logic        interrupt_taken,
  output logic        ecall_exception,
  output logic        ebreak_exception,
  output logic        mret_instruction,
  output logic [31:0] interrupt_cause,
  output logic [31:0] interrupt_pc,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy,
  output logic        drain_error
);

  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_t;
  typedef enum logic [1:0] {K_IRQ, K_ECALL, K_EBREAK, K_MRET} kind_t;

  localparam logic [7:0] DRAIN_LAST = 8'(MAX_DRAIN - 1);

  state_t      state, state_nx;
  kind_t       kind, kind_nx;
  logic        aborted;
  logic [7:0]  drain_cnt;
  logic [31:0] pend;
  logic        irq;
  logic [31:0] irq_cause;
  logic        event_present;
  logic        drain_timeout;
  logic        drain_done;
  logic [31:0] trap_base;
  logic [31:0] trap_target;
  logic        unused_mstatus;

  assign unused_mstatus = ^{mstatus[31:4], mstatus[2:0]};

  assign pend          = mie & mip & 32'h0000_0888;
  assign irq           = mstatus[3] & (|pend);
  assign event_present = ex_valid & (irq | ecall_in | ebreak_in | mret_in);
  assign drain_timeout = (drain_cnt == DRAIN_LAST);
  assign drain_done    = pipe_drained | drain_timeout;

  always_comb begin
    irq_cause = 32'h8000_0007;
    if (pend[11])     irq_cause = 32'h8000_000B;
    else if (pend[3]) irq_cause = 32'h8000_0003;
  end

  always_comb begin
    kind_nx = K_MRET;
    if (irq)            kind_nx = K_IRQ;
    else if (ecall_in)  kind_nx = K_ECALL;
    else if (ebreak_in) kind_nx = K_EBREAK;
  end

  // Vectored mode applies to interrupts only; exceptions always use the base.
  always_comb begin
    trap_base   = {mtvec[31:2], 2'b00};
    trap_target = trap_base;
    if (mtvec[1:0] == 2'b01 && kind == K_IRQ)
      trap_target = trap_base + {25'd0, interrupt_cause[4:0], 2'b00};
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (event_present) state_nx = DRAIN;
      DRAIN:    if (drain_done)    state_nx = COMMIT;
      COMMIT:   state_nx = REDIRECT;
      REDIRECT: state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      kind            <= K_IRQ;
      aborted         <= 1'b0;
      drain_cnt       <= '0;
      drain_error     <= 1'b0;
      interrupt_cause <= '0;
      interrupt_pc    <= '0;
      redirect_pc     <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (event_present) begin
            kind         <= kind_nx;
            interrupt_pc <= ex_pc;
            drain_cnt    <= '0;
            aborted      <= 1'b0;
            if (irq) interrupt_cause <= irq_cause;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 8'd1;
          if (!pipe_drained && drain_timeout) drain_error <= 1'b1;
          // An interrupt that vanished while draining is replayed, not taken.
          if (drain_done && kind == K_IRQ && !irq) aborted <= 1'b1;
        end
        COMMIT: begin
          if (aborted)             redirect_pc <= interrupt_pc;
          else if (kind == K_MRET) redirect_pc <= mepc;
          else                     redirect_pc <= trap_target;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stall_req        = 1'b0;
    flush_req        = 1'b0;
    busy             = 1'b0;
    redirect_valid   = 1'b0;
    interrupt_taken  = 1'b0;
    ecall_exception  = 1'b0;
    ebreak_exception = 1'b0;
    mret_instruction = 1'b0;
    case (state)
      DRAIN: begin
        stall_req = 1'b1;
        flush_req = 1'b1;
        busy      = 1'b1;
      end
      COMMIT: begin
        stall_req = 1'b1;
        busy      = 1'b1;
        if (!aborted) begin
          interrupt_taken  = (kind == K_IRQ);
          ecall_exception  = (kind == K_ECALL);
          ebreak_exception = (kind == K_EBREAK);
          mret_instruction = (kind == K_MRET);
        end
      end
      REDIRECT: begin
        stall_req      = 1'b1;
        busy           = 1'b1;
        redirect_valid = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
